// File: rtl/mult_share_arb_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
// Operand mode encoding and a constant clog2 used for ID widths.
package mult_share_arb_pkg;

    localparam logic TC_UNSIGNED = 1'b0;
    localparam logic TC_SIGNED   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/result bus of mult_share_arb: per-requester operands in, single result stream out.
interface mult_share_arb_if #(
    parameter int NREQ    = 4,
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 16
);
    import mult_share_arb_pkg::*;
    localparam int IDW = clog2(NREQ);

    logic                      EN;
    logic [NREQ-1:0]           REQ_VLD;
    logic [NREQ-1:0]           REQ_RDY;
    logic [NREQ*A_width-1:0]   REQ_A;
    logic [NREQ*B_width-1:0]   REQ_B;
    logic [NREQ-1:0]           REQ_TC;
    logic                      RES_VLD;
    logic [IDW-1:0]            RES_ID;
    logic [P_width-1:0]        RES_PRODUCT;
    logic                      BUSY;

    modport master (
        output EN, REQ_VLD, REQ_A, REQ_B, REQ_TC,
        input  REQ_RDY, RES_VLD, RES_ID, RES_PRODUCT, BUSY
    );

    modport slave (
        input  EN, REQ_VLD, REQ_A, REQ_B, REQ_TC,
        output REQ_RDY, RES_VLD, RES_ID, RES_PRODUCT, BUSY
    );

endinterface

// File: rtl/mult_share_arb_mult.sv
// Pipelined signed/unsigned multiplier, DELAY register stages, MSB-aligned product slice.
module mult_pipe
    import mult_share_arb_pkg::*;
#(
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 16,
    parameter int DELAY   = 2
) (
    input  logic               CLK,
    input  logic [A_width-1:0] i_a,
    input  logic [B_width-1:0] i_b,
    input  logic               i_tc,
    output logic [P_width-1:0] o_p
);
    localparam int FW = A_width + B_width;

    logic                            w_sa;
    logic                            w_sb;
    logic signed [FW-1:0]            w_a_ext;
    logic signed [FW-1:0]            w_b_ext;
    logic signed [FW-1:0]            w_full;
    logic [P_width-1:0]              w_p;
    logic [DELAY-1:0][P_width-1:0]   r_pipe;

    // Extending both operands to the full product width keeps the modular product exact,
    // including most-negative operands in signed mode.
    assign w_sa    = (i_tc == TC_SIGNED) && i_a[A_width-1];
    assign w_sb    = (i_tc == TC_SIGNED) && i_b[B_width-1];
    assign w_a_ext = {{B_width{w_sa}}, i_a};
    assign w_b_ext = {{A_width{w_sb}}, i_b};
    assign w_full  = w_a_ext * w_b_ext;
    assign w_p     = P_width'(w_full >>> (FW - P_width));

    always_ff @(posedge CLK) begin
        r_pipe[0] <= w_p;
        for (int s = 1; s < DELAY; s++) r_pipe[s] <= r_pipe[s-1];
    end

    assign o_p = r_pipe[DELAY-1];

endmodule

// File: rtl/mult_share_arb_rr_arb.sv
// Round-robin grant: first set request strictly after i_ptr, wrapping; one-hot output.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant
);

    logic w_found;

    // Two passes over constant indices: above the pointer first, then the wrapped part.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (i > int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i] && (i <= int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// NREQ requesters share one pipelined multiplier through a round-robin arbiter.
// Define MULT_SHARE_ARB_PRIO_EN to give requester 0 strict priority over the rest.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DELAY   = 2,
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 16
) (
    input  logic             CLK,
    input  logic             RST,
    mult_share_arb_if.slave  bus
);
    localparam int IDW = clog2(NREQ);

    logic [NREQ-1:0]          w_rr_req;
    logic [NREQ-1:0]          w_rr_grant;
    logic [NREQ-1:0]          w_grant;
    logic [NREQ-1:0]          w_rdy;
    logic                     w_xfer;
    logic                     w_ptr_ld;
    logic [IDW-1:0]           w_idx;
    logic [A_width-1:0]       w_a;
    logic [B_width-1:0]       w_b;
    logic                     w_tc;
    logic [P_width-1:0]       w_prod;

    logic [IDW-1:0]           r_ptr;
    logic [DELAY:0]           r_vld_pipe;
    logic [DELAY:0][IDW-1:0]  r_id_pipe;
    logic [A_width-1:0]       r_iss_a;
    logic [B_width-1:0]       r_iss_b;
    logic                     r_iss_tc;

`ifdef MULT_SHARE_ARB_PRIO_EN
    // Requester 0 bypasses the ring; the pointer only tracks the others.
    assign w_rr_req = bus.REQ_VLD & ~NREQ'(1);
    assign w_grant  = bus.REQ_VLD[0] ? NREQ'(1) : w_rr_grant;
    assign w_ptr_ld = w_xfer && (w_idx != '0);
`else
    assign w_rr_req = bus.REQ_VLD;
    assign w_grant  = w_rr_grant;
    assign w_ptr_ld = w_xfer;
`endif

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .i_req   (w_rr_req),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant)
    );

    assign w_rdy       = w_grant & {NREQ{bus.EN & ~RST}};
    assign w_xfer      = |w_rdy;
    assign bus.REQ_RDY = w_rdy;

    always_comb begin
        w_idx = '0;
        w_a   = '0;
        w_b   = '0;
        w_tc  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_idx = IDW'(i);
                w_a   = bus.REQ_A[i*A_width +: A_width];
                w_b   = bus.REQ_B[i*B_width +: B_width];
                w_tc  = bus.REQ_TC[i];
            end
        end
    end

    // Issue stage plus tag valid pipeline; stage 0 is the issue register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld_pipe <= '0;
            r_ptr      <= IDW'(NREQ-1);
            r_iss_tc   <= TC_UNSIGNED;
        end else begin
            r_vld_pipe <= {r_vld_pipe[DELAY-1:0], w_xfer};
            if (w_ptr_ld) r_ptr <= w_idx;
            if (w_xfer) begin
                r_iss_a  <= w_a;
                r_iss_b  <= w_b;
                r_iss_tc <= w_tc;
            end
        end
    end

    // IDs ride alongside the valid bits; they are masked at the output when invalid.
    always_ff @(posedge CLK) begin
        r_id_pipe[0] <= w_idx;
        for (int s = 1; s <= DELAY; s++) r_id_pipe[s] <= r_id_pipe[s-1];
    end

    mult_pipe #(
        .A_width (A_width),
        .B_width (B_width),
        .P_width (P_width),
        .DELAY   (DELAY)
    ) u_mult (
        .CLK  (CLK),
        .i_a  (r_iss_a),
        .i_b  (r_iss_b),
        .i_tc (r_iss_tc),
        .o_p  (w_prod)
    );

    assign bus.RES_VLD     = r_vld_pipe[DELAY];
    assign bus.RES_ID      = r_vld_pipe[DELAY] ? r_id_pipe[DELAY] : '0;
    assign bus.RES_PRODUCT = r_vld_pipe[DELAY] ? w_prod : '0;
    assign bus.BUSY        = |r_vld_pipe;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (NREQ=4, DELAY=2, 8x8->16); honours MULT_SHARE_ARB_PRIO_EN.
module tb_mult_share_arb;
    localparam int NREQ  = 4;
    localparam int DELAY = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mult_share_arb_if #(.NREQ(NREQ), .A_width(8), .B_width(8), .P_width(16)) bus ();

    mult_share_arb #(
        .NREQ(NREQ), .DELAY(DELAY), .A_width(8), .B_width(8), .P_width(16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic tc);
        bus.REQ_A[i*8 +: 8] = a;
        bus.REQ_B[i*8 +: 8] = b;
        bus.REQ_TC[i]       = tc;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.REQ_VLD = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.EN = 1'b1;
        bus.REQ_VLD = 4'hF;
        tick();
        tick();
        n_cmp++; if (bus.REQ_RDY !== 4'h0) begin n_err++; $display("FAIL reset.rdy got %h want 0", bus.REQ_RDY); end
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL reset.res_vld got %b want 0", bus.RES_VLD); end
        n_cmp++; if (bus.RES_ID !== 2'd0) begin n_err++; $display("FAIL reset.res_id got %h want 0", bus.RES_ID); end
        n_cmp++; if (bus.RES_PRODUCT !== 16'h0) begin n_err++; $display("FAIL reset.product got %h want 0", bus.RES_PRODUCT); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset.busy got %b want 0", bus.BUSY); end
        bus.REQ_VLD = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_req(2, 8'hFF, 8'h02, 1'b0);
        bus.REQ_VLD = 4'b0100;
        #1;
        n_cmp++; if (bus.REQ_RDY !== 4'b0100) begin n_err++; $display("FAIL single.rdy got %b want 0100", bus.REQ_RDY); end
        tick();
        bus.REQ_VLD = '0;
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL single.busy got %b want 1", bus.BUSY); end
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL single.early1 got %b want 0", bus.RES_VLD); end
        tick();
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL single.early2 got %b want 0", bus.RES_VLD); end
        tick();
        n_cmp++; if (bus.RES_VLD !== 1'b1) begin n_err++; $display("FAIL single.res_vld got %b want 1", bus.RES_VLD); end
        n_cmp++; if (bus.RES_ID !== 2'd2) begin n_err++; $display("FAIL single.res_id got %0d want 2", bus.RES_ID); end
        n_cmp++; if (bus.RES_PRODUCT !== 16'h01FE) begin n_err++; $display("FAIL single.product got %h want 01fe", bus.RES_PRODUCT); end
        tick();
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL single.one_shot got %b want 0", bus.RES_VLD); end
        n_cmp++; if (bus.RES_PRODUCT !== 16'h0) begin n_err++; $display("FAIL single.zeroed got %h want 0", bus.RES_PRODUCT); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL single.idle got %b want 0", bus.BUSY); end
    endtask

    // Requester 1 held valid with a new operand set every cycle (pointer is 2 on entry).
    task automatic test_signed();
        logic [7:0]  a_t [8] = '{8'hFD, 8'h80, 8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h80, 8'hFF};
        logic [7:0]  b_t [8] = '{8'h05, 8'h80, 8'h01, 8'h01, 8'h00, 8'hFB, 8'h7F, 8'hFF};
        logic        c_t [8] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [15:0] p_t [8] = '{16'hFFF1, 16'h4000, 16'hFFFF, 16'h00FF,
                                 16'h0000, 16'h0000, 16'hC080, 16'hFE01};
        for (int t = 0; t < 8 + DELAY + 1; t++) begin
            if (t < 8) begin
                set_req(1, a_t[t], b_t[t], c_t[t]);
                bus.REQ_VLD = 4'b0010;
            end else begin
                bus.REQ_VLD = '0;
            end
            #1;
            if (t < 8) begin
                n_cmp++; if (bus.REQ_RDY !== 4'b0010) begin n_err++; $display("FAIL signed.rdy t=%0d got %b want 0010", t, bus.REQ_RDY); end
            end
            if (t >= DELAY + 1) begin
                n_cmp++;
                if (bus.RES_VLD !== 1'b1 || bus.RES_ID !== 2'd1 || bus.RES_PRODUCT !== p_t[t-DELAY-1]) begin
                    n_err++;
                    $display("FAIL signed.res t=%0d got vld=%b id=%0d p=%h want vld=1 id=1 p=%h",
                             t, bus.RES_VLD, bus.RES_ID, bus.RES_PRODUCT, p_t[t-DELAY-1]);
                end
            end else begin
                n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL signed.early t=%0d got %b want 0", t, bus.RES_VLD); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int rdy_t [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
        int id_t  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int p_t   [8] = '{3, 6, 9, 12, 3, 6, 9, 12};
        int j;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'h03, 1'b0);
        for (int t = 0; t < 8 + DELAY + 1; t++) begin
            bus.REQ_VLD = (t < 8) ? 4'hF : 4'h0;
            #1;
            n_cmp++;
            if (bus.REQ_RDY !== ((t < 8) ? 4'(rdy_t[t]) : 4'h0)) begin
                n_err++; $display("FAIL rr.rdy t=%0d got %b want %b", t, bus.REQ_RDY, (t < 8) ? 4'(rdy_t[t]) : 4'h0);
            end
            j = t - DELAY - 1;
            if (j >= 0 && j < 8) begin
                n_cmp++;
                if (bus.RES_VLD !== 1'b1 || bus.RES_ID !== 2'(id_t[j]) || bus.RES_PRODUCT !== 16'(p_t[j])) begin
                    n_err++;
                    $display("FAIL rr.res t=%0d got vld=%b id=%0d p=%h want vld=1 id=%0d p=%h",
                             t, bus.RES_VLD, bus.RES_ID, bus.RES_PRODUCT, id_t[j], 16'(p_t[j]));
                end
            end
            tick();
        end
    endtask

    task automatic test_enable();
        int en_t   [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int vld_t  [11] = '{3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0};
        int rdy_t  [11] = '{1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 0};
        int rv_t   [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        int rid_t  [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        int p_t    [11] = '{0, 0, 0, 'h20, 'h22, 0, 0, 0, 'h20, 'h22, 0};
        int busy_t [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        pulse_reset();
        set_req(0, 8'h10, 8'h02, 1'b0);
        set_req(1, 8'h11, 8'h02, 1'b0);
        for (int t = 0; t < 11; t++) begin
            bus.EN      = en_t[t][0];
            bus.REQ_VLD = 4'(vld_t[t]);
            #1;
            n_cmp++;
            if (bus.REQ_RDY !== 4'(rdy_t[t])) begin
                n_err++; $display("FAIL en.rdy t=%0d got %b want %b", t, bus.REQ_RDY, 4'(rdy_t[t]));
            end
            n_cmp++;
            if (bus.RES_VLD !== rv_t[t][0] || bus.RES_ID !== 2'(rid_t[t]) || bus.RES_PRODUCT !== 16'(p_t[t])) begin
                n_err++;
                $display("FAIL en.res t=%0d got vld=%b id=%0d p=%h want vld=%0d id=%0d p=%h",
                         t, bus.RES_VLD, bus.RES_ID, bus.RES_PRODUCT, rv_t[t], rid_t[t], 16'(p_t[t]));
            end
            n_cmp++;
            if (bus.BUSY !== busy_t[t][0]) begin
                n_err++; $display("FAIL en.busy t=%0d got %b want %0d", t, bus.BUSY, busy_t[t]);
            end
            tick();
        end
        bus.EN = 1'b1;
    endtask

    // Pointer is 1 on entry from test_enable.
    task automatic test_reset_inflight();
        set_req(2, 8'h03, 8'h03, 1'b0);
        set_req(3, 8'h04, 8'h04, 1'b0);
        set_req(0, 8'h07, 8'h06, 1'b0);
        bus.REQ_VLD = 4'b0100;
        #1;
        n_cmp++; if (bus.REQ_RDY !== 4'b0100) begin n_err++; $display("FAIL rstf.rdy0 got %b want 0100", bus.REQ_RDY); end
        tick();
        bus.REQ_VLD = 4'b1000;
        #1;
        n_cmp++; if (bus.REQ_RDY !== 4'b1000) begin n_err++; $display("FAIL rstf.rdy1 got %b want 1000", bus.REQ_RDY); end
        tick();
        rst = 1'b1;
        bus.REQ_VLD = 4'hF;
        #1;
        n_cmp++; if (bus.REQ_RDY !== 4'h0) begin n_err++; $display("FAIL rstf.rdy_in_rst got %b want 0", bus.REQ_RDY); end
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL rstf.busy_pre got %b want 1", bus.BUSY); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.REQ_RDY !== 4'b0001) begin n_err++; $display("FAIL rstf.first_grant got %b want 0001", bus.REQ_RDY); end
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL rstf.busy_post got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL rstf.ghost0 got %b want 0", bus.RES_VLD); end
        tick();
        bus.REQ_VLD = '0;
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL rstf.ghost1 got %b want 0", bus.RES_VLD); end
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_err++; $display("FAIL rstf.busy_new got %b want 1", bus.BUSY); end
        tick();
        n_cmp++; if (bus.RES_VLD !== 1'b0) begin n_err++; $display("FAIL rstf.ghost2 got %b want 0", bus.RES_VLD); end
        tick();
        n_cmp++;
        if (bus.RES_VLD !== 1'b1 || bus.RES_ID !== 2'd0 || bus.RES_PRODUCT !== 16'h002A) begin
            n_err++;
            $display("FAIL rstf.res got vld=%b id=%0d p=%h want vld=1 id=0 p=002a", bus.RES_VLD, bus.RES_ID, bus.RES_PRODUCT);
        end
        tick();
    endtask

    task automatic test_priority();
        int vld_t [8] = '{9, 9, 9, 9, 9, 9, 8, 0};
`ifdef MULT_SHARE_ARB_PRIO_EN
        int rdy_t [8] = '{1, 1, 1, 1, 1, 1, 8, 0};
`else
        int rdy_t [8] = '{1, 8, 1, 8, 1, 8, 8, 0};
`endif
        pulse_reset();
        for (int t = 0; t < 8; t++) begin
            bus.REQ_VLD = 4'(vld_t[t]);
            #1;
            n_cmp++;
            if (bus.REQ_RDY !== 4'(rdy_t[t])) begin
                n_err++; $display("FAIL prio.rdy t=%0d got %b want %b", t, bus.REQ_RDY, 4'(rdy_t[t]));
            end
            tick();
        end
        for (int t = 0; t < DELAY + 2; t++) tick();
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL prio.drain got %b want 0", bus.BUSY); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.EN = 1'b0;
        bus.REQ_VLD = '0;
        bus.REQ_A = '0;
        bus.REQ_B = '0;
        bus.REQ_TC = '0;
        test_reset();
        test_single();
        test_signed();
        test_back_to_back();
        test_enable();
        test_reset_inflight();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DELAY, default 2, multiplier pipeline depth (>=1).
REQ-003 Parameters A_width, B_width, P_width, defaults 8, 8, 16: operand widths and product width (P_width <= A_width+B_width, MSB-aligned slice).
REQ-004 Derived localparam IDW = clog2(NREQ).
REQ-005 CLK  in  1  sole clock; all logic rising-edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 EN  in  1  grant enable; low blocks new grants and leaves in-flight results unaffected.
REQ-008 REQ_VLD  in  NREQ  per-requester operand valid.
REQ-009 REQ_RDY  out  NREQ  per-requester accept, at most one bit set.
REQ-010 REQ_A  in  NREQ*A_width  packed operand A; requester i in slice i.
REQ-011 REQ_B  in  NREQ*B_width  packed operand B.
REQ-012 REQ_TC  in  NREQ  per-requester mode: 0 unsigned, 1 signed.
REQ-013 RES_VLD  out  1  result valid, single cycle per accepted request.
REQ-014 RES_ID  out  IDW  requester index of the result.
REQ-015 RES_PRODUCT  out  P_width  product, upper P_width bits of the full product.
REQ-016 BUSY  out  1  high while any accepted request has not yet produced RES_VLD.

Function
REQ-017 Round-robin arbitration: search starts at last-granted index +1, wraps modulo NREQ; first requester with REQ_VLD=1 wins.
REQ-018 REQ_RDY[i] is combinational from REQ_VLD, EN and pointer; REQ_RDY=0 whenever EN=0 or RST=1.
REQ-019 Handshake: a transfer occurs at an edge where REQ_VLD[i]&REQ_RDY[i]=1; requester must hold operands stable while VLD high and RDY low.
REQ-020 Pointer updates only on a transfer; idle cycles leave it unchanged.
REQ-021 Throughput: one transfer per cycle maximum; no stall (result bus has no backpressure).
REQ-022 Winner operands, TC and index are registered at the transfer edge (issue stage), then fed to the multiplier.
REQ-023 Latency: transfer at edge k -> RES_VLD=1 with matching RES_ID/RES_PRODUCT sampled at edge k+DELAY+1; results return in issue order.
REQ-024 Tag pipeline: valid bit plus IDW-bit ID, DELAY+1 stages deep, aligned with the multiplier data path.
REQ-025 RES_PRODUCT and RES_ID are forced to 0 when RES_VLD=0.
REQ-026 Signed mode: two's-complement product; -A*0 and 0*-B give 0; most-negative operands handled by full-width arithmetic.
REQ-027 BUSY = OR of tag-pipeline valid bits.
REQ-028 EN falling mid-stream: already-accepted requests complete normally; RDY drops in the same cycle.

Reset
REQ-029 RST clears tag valid bits, issue-stage valid and pointer (pointer = NREQ-1, so requester 0 wins first).
REQ-030 Reset mid-operation discards all in-flight requests; no RES_VLD for them after RST deasserts.
REQ-031 Output values in and after reset: REQ_RDY=0 during RST, RES_VLD=0, RES_ID=0, RES_PRODUCT=0, BUSY=0.

Configuration
REQ-032 Macro MULT_SHARE_ARB_PRIO_EN defined: requester 0 has strict priority over all others; remaining requesters round-robin among themselves.
REQ-033 Macro undefined: pure round-robin across all NREQ requesters, per REQ-017.

Structure
REQ-034 Shared package holds the TC encoding constants and the clog2 function.
REQ-035 One sub-module rr_arb (request vector, pointer -> one-hot grant); multiplier is the existing team pipelined multiplier, instantiated once.

Verification
REQ-036 Single requester: A=8'hFF, B=8'h02, TC=0 on req 2 -> RES_VLD after DELAY+1 edges, RES_ID=2, RES_PRODUCT=16'h01FE.
REQ-037 Signed: A=8'hFD (-3), B=8'h05, TC=1 -> RES_PRODUCT=16'hFFF1; A=8'h80, B=8'h80 -> 16'h4000.
REQ-038 All four VLD held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; RES_ID stream identical, back-to-back RES_VLD.
REQ-039 EN low for 3 cycles during a stream -> no RDY in those cycles, in-flight results still appear, BUSY falls then rises again.
REQ-040 RST pulsed one cycle with 2 requests in flight -> no RES_VLD afterwards for them, BUSY=0, next grant goes to requester 0.
REQ-041 With MULT_SHARE_ARB_PRIO_EN, req 0 and req 3 continuously valid -> req 0 granted every cycle, req 3 never granted until req 0 drops.
